delay_sequencer: RTL

- Initiator side of the game's delay-timer interface.
- Accepts delay requests from several game-logic clients (mismatch hold, match flash, turn pacing) and arbitrates between them with fixed priority.
- Drives one shared timer's start_timer/delay pair and consumes its timer_done flag.
- Returns a per-client done pulse, and runs a watchdog that aborts a run if the timer never completes.

---
 rtl/delay_sequencer_pkg.sv | 12 +
 rtl/prio_arbiter.sv | 27 ++
 rtl/delay_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/delay_sequencer_pkg.sv
// rtl/delay_sequencer_pkg.sv - shared delay-timer widths and sequencer state encodings
package delay_sequencer_pkg;

    localparam int DELAY_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/prio_arbiter.sv
// rtl/prio_arbiter.sv - combinational lowest-index-wins one-hot grant with encoded index
module prio_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    // Scan from the top so the lowest set index overwrites any higher one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = i[IDX_W-1:0];
            end
        end
    end

    assign grant_any = |req;

endmodule

// File: rtl/delay_sequencer.sv
// rtl/delay_sequencer.sv - arbitrates client delay requests onto one shared timer with watchdog
module delay_sequencer
    import delay_sequencer_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int DELAY_W  = DELAY_W_DEF,
    parameter int WD_SLACK = 4,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    input  logic                       cancel,
    input  logic                       timer_done,
    output logic                       start_timer,
    output logic [DELAY_W-1:0]         delay,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic                       aborted,
    output logic                       busy,
    output logic [ID_W-1:0]            active_id,
    output logic                       timeout_err
);

    seq_state_t           state, state_n;
    logic [DELAY_W:0]     wd_cnt, wd_cnt_n, wd_limit;
    logic                 start_n, aborted_n, busy_n, terr_n;
    logic [DELAY_W-1:0]   delay_n;
    logic [NUM_REQ-1:0]   ack_n, done_n;
    logic [ID_W-1:0]      id_n;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_any;

    prio_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // wd_cnt starts one cycle after ack, hence the +1 to land WD_SLACK past the nominal done.
    assign wd_limit = {1'b0, delay} + (DELAY_W + 1)'(WD_SLACK) + (DELAY_W + 1)'(1);

    always_comb begin
        state_n   = state;
        start_n   = start_timer;
        delay_n   = delay;
        ack_n     = '0;
        done_n    = '0;
        aborted_n = 1'b0;
        busy_n    = busy;
        id_n      = active_id;
        terr_n    = timeout_err;
        wd_cnt_n  = wd_cnt;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    delay_n  = req_delay[grant_idx*DELAY_W +: DELAY_W];
                    id_n     = grant_idx;
                    ack_n    = grant;
                    start_n  = 1'b1;
                    busy_n   = 1'b1;
                    wd_cnt_n = '0;
                    state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_cnt_n = wd_cnt + 1'b1;
                if (timer_done) begin
                    start_n = 1'b0;
                    done_n  = NUM_REQ'(1) << active_id;
                    state_n = ST_GAP;
                end else if (cancel) begin
                    start_n   = 1'b0;
                    aborted_n = 1'b1;
                    state_n   = ST_GAP;
                end else if (wd_cnt == wd_limit) begin
                    start_n   = 1'b0;
                    aborted_n = 1'b1;
                    terr_n    = 1'b1;
                    state_n   = ST_GAP;
                end
            end
            ST_GAP: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                start_n = 1'b0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            start_timer <= 1'b0;
            delay       <= '0;
            ack         <= '0;
            done        <= '0;
            aborted     <= 1'b0;
            busy        <= 1'b0;
            active_id   <= '0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_n;
            start_timer <= start_n;
            delay       <= delay_n;
            ack         <= ack_n;
            done        <= done_n;
            aborted     <= aborted_n;
            busy        <= busy_n;
            active_id   <= id_n;
            timeout_err <= terr_n;
            wd_cnt      <= wd_cnt_n;
        end
    end

endmodule
